redmule_job_ctx: RTL and testbench
==================================

REDMULE_JOB_CTX -- requirements
Module: redmule_job_ctx

Interface
REQ-001 SHALL have parameter N_CONTEXT, default 2: number of job contexts, power of two, at least 2.
REQ-002 SHALL have parameter N_REGS, default 19: 32-bit registers per context.
REQ-003 SHALL have one clock and an asynchronous, active-low reset, as decided: clk_i input 1 (rising-edge clock), then rst_ni input 1 (asynchronous active-low reset).
REQ-004 SHALL have port clear_i input 1: synchronous soft clear.
REQ-005 SHALL have port cfg_we_i input 1: config write strobe.
REQ-006 SHALL have port cfg_addr_i input $clog2(N_REGS): register index.
REQ-007 SHALL have port cfg_wdata_i input 32: write data.
REQ-008 SHALL have port cfg_be_i input 4: byte enables.
REQ-009 SHALL have port commit_i input 1: staging context ready to run.
REQ-010 SHALL have port commit_err_o output 1: one-cycle pulse when a commit is rejected.
REQ-011 SHALL have ports full_o output 1 and empty_o output 1: context occupancy.
REQ-012 SHALL have port pending_o output $clog2(N_CONTEXT)+1: count of committed, unretired jobs.
REQ-013 SHALL have port job_valid_o output 1 and job_ready_i input 1: job offer handshake.
REQ-014 SHALL have port job_id_o output $clog2(N_CONTEXT): slot index of the head job.
REQ-015 SHALL have port job_regs_o output N_REGS x 32: head slot contents.
REQ-016 SHALL have port job_done_i input 1: the engine retires the running job.
REQ-017 SHALL have port busy_o output 1: a job is running.
REQ-018 SHALL have port perf_cycles_o output 32: cycle count of the last retired job.

Function
REQ-019 SHALL keep a circular buffer of N_CONTEXT slots with write pointer wptr (staging slot), read pointer rptr (head) and counter cnt.
REQ-020 SHALL apply cfg_we_i to slot wptr, register cfg_addr_i, per enabled byte, in the same cycle, only when cnt < N_CONTEXT.
REQ-021 SHALL ignore writes with cfg_addr_i >= N_REGS and writes while full; neither generates an error.
REQ-022 On commit_i with cnt < N_CONTEXT (pre-cycle value), SHALL advance wptr modulo N_CONTEXT and increment cnt; otherwise SHALL pulse commit_err_o for one cycle and leave state unchanged.
REQ-023 SHALL drive full_o = (cnt == N_CONTEXT), empty_o = (cnt == 0) and pending_o = cnt, all registered.
REQ-024 Engine FSM SHALL have states IDLE, OFFER and RUN.
REQ-025 IDLE -> OFFER when cnt > 0 at the clock edge.
REQ-026 In OFFER, job_valid_o = 1; job_id_o = rptr; job_regs_o = slot rptr. These SHALL stay stable until job_ready_i is high.
REQ-027 OFFER -> RUN on job_valid_o && job_ready_i; busy_o = 1 in RUN only.
REQ-028 RUN -> IDLE on job_done_i: rptr advances modulo N_CONTEXT and cnt decrements.
REQ-029 job_done_i outside RUN SHALL be ignored.
REQ-030 Commit and retire in the same cycle SHALL both take effect with cnt unchanged; a commit when full in that cycle is still rejected.
REQ-031 Slot rptr SHALL be write-protected from OFFER entry until retire; job_regs_o never changes during RUN.
REQ-032 Minimum latency SHALL be: commit at cycle t -> job_valid_o at t+2.
REQ-033 clear_i SHALL have the same effect as reset, one cycle later; clear_i has priority over all other inputs in that cycle.

Reset
REQ-034 On rst_ni low, all slot registers, wptr, rptr, cnt and perf_cycles_o SHALL be 0, the FSM SHALL be IDLE, commit_err_o, job_valid_o and busy_o SHALL be 0, empty_o SHALL be 1 and full_o SHALL be 0.
REQ-035 Reset asserted mid-job SHALL abandon the job; no retire is reported.

Configuration
REQ-036 Macro REDMULE_JOB_CTX_PERF_EN defined: a 32-bit counter SHALL clear on OFFER->RUN, increment each RUN cycle and saturate at 2^32-1; its value including the done cycle SHALL load into perf_cycles_o on retire.
REQ-037 Macro REDMULE_JOB_CTX_PERF_EN undefined: no counter logic SHALL be present and perf_cycles_o SHALL be tied to 0; all other behaviour SHALL be identical.

Verification
REQ-038 Write reg 18 = 0x0000_1234 with be=0011, commit, ready=1 -> at t+2 job_valid_o=1, job_id_o=0, job_regs_o[18]=0x0000_1234, other regs 0.
REQ-039 N_CONTEXT=2: commit three times with no done -> full_o=1 after two commits, third commit gives commit_err_o pulse, pending_o=2.
REQ-040 Full buffer, commit and job_done_i in the same cycle -> commit rejected, pending_o drops to 1, rptr=1.
REQ-041 Hold job_ready_i=0 for 5 cycles while writing slot rptr -> job_regs_o unchanged, job_valid_o held at 1.
REQ-042 PERF_EN defined, RUN lasting 10 cycles including the done cycle -> perf_cycles_o=10; PERF_EN undefined -> perf_cycles_o=0.
REQ-043 rst_ni low during RUN with 2 pending -> all outputs at reset values the same cycle, pending_o=0, and no job_valid_o until a new commit.

Source files
------------

// File: rtl/redmule_job_ctx.sv
// ---------------------------------------------------------------------------
// redmule_job_ctx
//
// Job-context buffer for the RedMulE engine. Software fills a staging
// context through byte-enabled register writes and commits it. Committed
// contexts queue in a circular buffer of N_CONTEXT slots. The head context
// is offered to the engine with a valid/ready handshake. It stays
// write-protected and stable until the engine reports job_done_i.
//
// Optional feature: define REDMULE_JOB_CTX_PERF_EN to add a saturating
// 32-bit RUN-cycle counter. Its value is latched into perf_cycles_o when a
// job retires. With the macro undefined, perf_cycles_o is tied to 0.
//
// Ports
//   clk_i, rst_ni      clock, asynchronous active-low reset
//   clear_i            synchronous soft clear (same effect as reset)
//   cfg_we_i/addr/wdata/be  register write into the staging slot
//   commit_i           staging slot ready to run
//   commit_err_o       one-cycle pulse: commit rejected (buffer full)
//   full_o, empty_o    occupancy flags
//   pending_o          committed, not yet retired jobs
//   job_valid_o/ready_i, job_id_o, job_regs_o   head job offer
//   job_done_i         engine retires the running job
//   busy_o             a job is running
//   perf_cycles_o      RUN cycles of the last retired job
// ---------------------------------------------------------------------------
module redmule_job_ctx #(
    parameter int unsigned N_CONTEXT = 2,
    parameter int unsigned N_REGS    = 19
) (
    input  logic                            clk_i,
    input  logic                            rst_ni,
    input  logic                            clear_i,
    input  logic                            cfg_we_i,
    input  logic [$clog2(N_REGS)-1:0]       cfg_addr_i,
    input  logic [31:0]                     cfg_wdata_i,
    input  logic [3:0]                      cfg_be_i,
    input  logic                            commit_i,
    output logic                            commit_err_o,
    output logic                            full_o,
    output logic                            empty_o,
    output logic [$clog2(N_CONTEXT):0]      pending_o,
    output logic                            job_valid_o,
    input  logic                            job_ready_i,
    output logic [$clog2(N_CONTEXT)-1:0]    job_id_o,
    output logic [N_REGS-1:0][31:0]         job_regs_o,
    input  logic                            job_done_i,
    output logic                            busy_o,
    output logic [31:0]                     perf_cycles_o
);

    localparam int unsigned AW = $clog2(N_REGS);
    localparam int unsigned PW = $clog2(N_CONTEXT);
    localparam int unsigned CW = PW + 1;
    localparam logic [CW-1:0] CNT_FULL  = CW'(N_CONTEXT);
    localparam logic [AW:0]   REG_LIMIT = (AW + 1)'(N_REGS);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_OFFER = 2'd1,
        ST_RUN   = 2'd2
    } state_e;

    state_e                                 state_r;
    state_e                                 state_s;
    logic [PW-1:0]                          wptr_r;
    logic [PW-1:0]                          rptr_r;
    logic [CW-1:0]                          cnt_r;
    logic [CW-1:0]                          cnt_s;
    logic                                   full_r;
    logic                                   empty_r;
    logic                                   commit_err_r;
    logic                                   job_valid_r;
    logic                                   busy_r;
    logic [N_CONTEXT-1:0][N_REGS-1:0][31:0] slots_r;

    logic                                   space_s;
    logic                                   commit_ok_s;
    logic                                   retire_s;
    logic                                   addr_ok_s;
    logic                                   protect_s;
    logic                                   wr_en_s;

    // All decisions use the pre-cycle occupancy, so a commit and a retire
    // in the same cycle never let a commit into a full buffer.
    assign space_s     = (cnt_r < CNT_FULL);
    assign commit_ok_s = commit_i & space_s;
    assign retire_s    = (state_r == ST_RUN) & job_done_i;
    assign addr_ok_s   = ({1'b0, cfg_addr_i} < REG_LIMIT);
    // The head slot is frozen from offer until retire. wptr only meets
    // rptr when the buffer is full, so this guard is a safety net.
    assign protect_s   = (state_r != ST_IDLE) & (wptr_r == rptr_r);
    assign wr_en_s     = cfg_we_i & space_s & addr_ok_s & ~protect_s;

    // Occupancy update: commit and retire together leave cnt unchanged.
    always_comb begin
        cnt_s = cnt_r;
        if (commit_ok_s && !retire_s) begin
            cnt_s = cnt_r + CW'(1);
        end else if (!commit_ok_s && retire_s) begin
            cnt_s = cnt_r - CW'(1);
        end else begin
            cnt_s = cnt_r;
        end
    end

    // Engine FSM next-state logic.
    always_comb begin
        state_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (cnt_r != CW'(0)) begin
                    state_s = ST_OFFER;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_OFFER: begin
                if (job_ready_i) begin
                    state_s = ST_RUN;
                end else begin
                    state_s = ST_OFFER;
                end
            end
            ST_RUN: begin
                if (job_done_i) begin
                    state_s = ST_IDLE;
                end else begin
                    state_s = ST_RUN;
                end
            end
            default: state_s = ST_IDLE;
        endcase
    end

    // FSM state, pointers, occupancy and registered status outputs.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_r      <= ST_IDLE;
            wptr_r       <= PW'(0);
            rptr_r       <= PW'(0);
            cnt_r        <= CW'(0);
            full_r       <= 1'b0;
            empty_r      <= 1'b1;
            commit_err_r <= 1'b0;
            job_valid_r  <= 1'b0;
            busy_r       <= 1'b0;
        end else if (clear_i) begin
            state_r      <= ST_IDLE;
            wptr_r       <= PW'(0);
            rptr_r       <= PW'(0);
            cnt_r        <= CW'(0);
            full_r       <= 1'b0;
            empty_r      <= 1'b1;
            commit_err_r <= 1'b0;
            job_valid_r  <= 1'b0;
            busy_r       <= 1'b0;
        end else begin
            state_r      <= state_s;
            cnt_r        <= cnt_s;
            full_r       <= (cnt_s == CNT_FULL);
            empty_r      <= (cnt_s == CW'(0));
            commit_err_r <= commit_i & ~space_s;
            job_valid_r  <= (state_s == ST_OFFER);
            busy_r       <= (state_s == ST_RUN);
            // N_CONTEXT is a power of two, so natural wrap is modulo N_CONTEXT.
            if (commit_ok_s) begin
                wptr_r <= wptr_r + PW'(1);
            end
            if (retire_s) begin
                rptr_r <= rptr_r + PW'(1);
            end
        end
    end

    // Context storage: byte-enabled writes into the staging slot.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            slots_r <= '0;
        end else if (clear_i) begin
            slots_r <= '0;
        end else if (wr_en_s) begin
            for (int b = 0; b < 4; b++) begin
                if (cfg_be_i[b]) begin
                    slots_r[wptr_r][cfg_addr_i][8*b +: 8] <= cfg_wdata_i[8*b +: 8];
                end
            end
        end
    end

`ifdef REDMULE_JOB_CTX_PERF_EN
    logic [31:0] perf_cnt_r;
    logic [31:0] perf_cycles_r;
    logic [31:0] perf_inc_s;

    // Saturating increment. On retire it already includes the done cycle.
    assign perf_inc_s = (perf_cnt_r == 32'hFFFF_FFFF) ? perf_cnt_r : (perf_cnt_r + 32'd1);

    // RUN-cycle counter and last-job latch.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            perf_cnt_r    <= 32'd0;
            perf_cycles_r <= 32'd0;
        end else if (clear_i) begin
            perf_cnt_r    <= 32'd0;
            perf_cycles_r <= 32'd0;
        end else begin
            if ((state_r == ST_OFFER) && job_ready_i) begin
                perf_cnt_r <= 32'd0;
            end else if (state_r == ST_RUN) begin
                perf_cnt_r <= perf_inc_s;
            end
            if (retire_s) begin
                perf_cycles_r <= perf_inc_s;
            end
        end
    end

    assign perf_cycles_o = perf_cycles_r;
`else
    assign perf_cycles_o = 32'd0;
`endif

    assign commit_err_o = commit_err_r;
    assign full_o       = full_r;
    assign empty_o      = empty_r;
    assign pending_o    = cnt_r;
    assign job_valid_o  = job_valid_r;
    assign busy_o       = busy_r;
    assign job_id_o     = rptr_r;
    assign job_regs_o   = slots_r[rptr_r];

endmodule

// File: tb/tb_redmule_job_ctx.sv
// ---------------------------------------------------------------------------
// tb_redmule_job_ctx
//
// Self-checking bench for redmule_job_ctx (N_CONTEXT=2, N_REGS=19).
// The reference model holds the slot memory, a FIFO of committed slot
// indices and the engine phase. After every clock edge the model predicts
// all outputs. Directed sequences come first, then a randomized run.
// ---------------------------------------------------------------------------
module tb_redmule_job_ctx;

    localparam int NC = 2;
    localparam int NR = 19;

    logic              clk;
    logic              rst_n;
    logic              clear;
    logic              we;
    logic [4:0]        addr;
    logic [31:0]       wdata;
    logic [3:0]        be;
    logic              commit;
    logic              commit_err;
    logic              full;
    logic              empty;
    logic [1:0]        pending;
    logic              job_valid;
    logic              job_ready;
    logic [0:0]        job_id;
    logic [NR-1:0][31:0] job_regs;
    logic              job_done;
    logic              busy;
    logic [31:0]       perf_cycles;

    redmule_job_ctx #(
        .N_CONTEXT (NC),
        .N_REGS    (NR)
    ) dut (
        .clk_i         (clk),
        .rst_ni        (rst_n),
        .clear_i       (clear),
        .cfg_we_i      (we),
        .cfg_addr_i    (addr),
        .cfg_wdata_i   (wdata),
        .cfg_be_i      (be),
        .commit_i      (commit),
        .commit_err_o  (commit_err),
        .full_o        (full),
        .empty_o       (empty),
        .pending_o     (pending),
        .job_valid_o   (job_valid),
        .job_ready_i   (job_ready),
        .job_id_o      (job_id),
        .job_regs_o    (job_regs),
        .job_done_i    (job_done),
        .busy_o        (busy),
        .perf_cycles_o (perf_cycles)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errs   = 0;

    // Reference model state
    logic [31:0] m_mem [NC][NR];
    int          m_q[$];
    int          m_wptr;
    int          m_phase;   // 0 idle, 1 offer, 2 run
    int          m_run_len;
    int          m_perf;
    bit          m_err;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errs++;
            $display("FAIL %s: got 0x%08h, want 0x%08h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic void m_reset();
        for (int s = 0; s < NC; s++)
            for (int r = 0; r < NR; r++)
                m_mem[s][r] = 32'd0;
        m_q.delete();
        m_wptr    = 0;
        m_phase   = 0;
        m_run_len = 0;
        m_perf    = 0;
        m_err     = 1'b0;
    endfunction

    function automatic void m_step();
        int pre_cnt;
        if (clear) begin
            m_reset();
            return;
        end
        pre_cnt = m_q.size();
        m_err   = commit && (pre_cnt >= NC);
        if (we && (pre_cnt < NC) && (int'(addr) < NR)) begin
            for (int b = 0; b < 4; b++)
                if (be[b]) m_mem[m_wptr][addr][8*b +: 8] = wdata[8*b +: 8];
        end
        case (m_phase)
            0: if (pre_cnt > 0) m_phase = 1;
            1: if (job_ready) begin m_phase = 2; m_run_len = 0; end
            2: begin
                m_run_len++;
                if (job_done) begin
                    m_perf  = m_run_len;
                    m_phase = 0;
                    void'(m_q.pop_front());
                end
            end
            default: m_phase = 0;
        endcase
        if (commit && (pre_cnt < NC)) begin
            m_q.push_back(m_wptr);
            m_wptr = (m_wptr + 1) % NC;
        end
    endfunction

    task automatic compare_all();
        int cnt;
        int exp_perf;
        cnt = m_q.size();
`ifdef REDMULE_JOB_CTX_PERF_EN
        exp_perf = m_perf;
`else
        exp_perf = 0;
`endif
        chk("pending",    32'(pending),    32'(cnt));
        chk("full",       32'(full),       32'(cnt == NC));
        chk("empty",      32'(empty),      32'(cnt == 0));
        chk("commit_err", 32'(commit_err), 32'(m_err));
        chk("job_valid",  32'(job_valid),  32'(m_phase == 1));
        chk("busy",       32'(busy),       32'(m_phase == 2));
        chk("perf",       perf_cycles,     32'(exp_perf));
        if ((m_phase != 0) && (cnt > 0)) begin
            chk("job_id", 32'(job_id), 32'(m_q[0]));
            for (int r = 0; r < NR; r++)
                chk($sformatf("job_regs[%0d]", r), job_regs[r], m_mem[m_q[0]][r]);
        end
    endtask

    task automatic idle_inputs();
        clear = 1'b0; we = 1'b0; addr = 5'd0; wdata = 32'd0; be = 4'd0;
        commit = 1'b0; job_ready = 1'b0; job_done = 1'b0;
    endtask

    task automatic tick();
        @(posedge clk);
        m_step();
        #1;
        compare_all();
    endtask

    initial begin
        idle_inputs();
        rst_n = 1'b0;
        m_reset();
        #12;
        compare_all();
        chk("rst_empty", 32'(empty), 32'd1);
        @(negedge clk);
        rst_n = 1'b1;

        // Single job: byte-enabled write, then commit -> offer two cycles later
        we = 1'b1; addr = 5'd18; wdata = 32'hFFFF_1234; be = 4'b0011;
        tick();
        idle_inputs();
        commit = 1'b1; job_ready = 1'b1;
        tick();                                   // cycle t+1
        chk("lat_valid_t1", 32'(job_valid), 32'd0);
        commit = 1'b0;
        tick();                                   // cycle t+2
        chk("lat_valid_t2", 32'(job_valid), 32'd1);
        chk("lat_id",       32'(job_id),    32'd0);
        chk("lat_reg18",    job_regs[18],   32'h0000_1234);
        chk("lat_reg0",     job_regs[0],    32'd0);
        tick();                                   // into RUN
        job_ready = 1'b0; job_done = 1'b1;
        tick();                                   // retire
        idle_inputs();
        clear = 1'b1;
        tick();
        clear = 1'b0;

        // Fill the buffer, then one commit too many
        commit = 1'b1;
        tick();
        tick();
        chk("fill_full", 32'(full), 32'd1);
        tick();
        chk("fill_err",     32'(commit_err), 32'd1);
        chk("fill_pending", 32'(pending),    32'd2);
        commit = 1'b0;
        tick();
        chk("err_pulse_end", 32'(commit_err), 32'd0);

        // Full buffer: commit and retire together
        job_ready = 1'b1;
        tick();
        job_ready = 1'b0; commit = 1'b1; job_done = 1'b1;
        tick();
        chk("cr_err",     32'(commit_err), 32'd1);
        chk("cr_pending", 32'(pending),    32'd1);
        idle_inputs();
        tick();
        chk("cr_rptr", 32'(job_id), 32'd1);

        // Stall the offer, refill to full, hammer writes at the head slot
        commit = 1'b1; we = 1'b1; addr = 5'd3; wdata = $urandom; be = 4'hF;
        tick();
        commit = 1'b0;
        for (int i = 0; i < 5; i++) begin
            addr = 5'($urandom_range(0, NR - 1)); wdata = $urandom;
            tick();
            chk("stall_valid", 32'(job_valid), 32'd1);
        end
        idle_inputs();

        // RUN lasting exactly 10 cycles including the done cycle
        job_ready = 1'b1;
        tick();
        job_ready = 1'b0;
        for (int i = 0; i < 9; i++) tick();
        job_done = 1'b1;
        tick();
        job_done = 1'b0;
`ifdef REDMULE_JOB_CTX_PERF_EN
        chk("perf10", perf_cycles, 32'd10);
`else
        chk("perf_off", perf_cycles, 32'd0);
`endif

        // Async reset during RUN with two jobs pending
        commit = 1'b1;
        tick();
        commit = 1'b0; job_ready = 1'b1;
        tick();
        job_ready = 1'b0;
        chk("pre_rst_busy",    32'(busy),    32'd1);
        chk("pre_rst_pending", 32'(pending), 32'd2);
        #2;
        rst_n = 1'b0;
        m_reset();
        #1;
        compare_all();
        chk("rst_pending", 32'(pending), 32'd0);
        chk("rst_busy",    32'(busy),    32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("rst_no_valid", 32'(job_valid), 32'd0);
        end

        // Randomized traffic
        for (int i = 0; i < 600; i++) begin
            clear     = ($urandom_range(0, 99) == 0);
            we        = $urandom_range(0, 1);
            addr      = 5'($urandom_range(0, 31));
            wdata     = $urandom;
            be        = 4'($urandom_range(0, 15));
            commit    = ($urandom_range(0, 3) == 0);
            job_ready = $urandom_range(0, 1);
            job_done  = ($urandom_range(0, 3) == 0);
            tick();
        end
        idle_inputs();

        $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_errs);
        $finish;
    end

endmodule
